// File: rtl/mem_resp_20b_if.sv
// -----------------------------------------------------------------------------
// mem_resp_20b_if
//
// Purpose:
//   Request/response bus between a requester (execution or fetch logic, or a
//   testbench) and the mem_resp_20b memory responder.
//
// Signals:
//   req    requester -> responder  request strobe, sampled only while busy=0
//   we     requester -> responder  1=write, 0=read
//   w      requester -> responder  1=word (16 bits), 0=byte
//   addr   requester -> responder  20-bit physical byte address
//   wdata  requester -> responder  write data (byte writes use wdata[7:0])
//   busy   responder -> requester  high from acceptance through the ack cycle
//   ack    responder -> requester  one-cycle completion pulse
//   err    responder -> requester  access rejected, valid with ack
//   rdata  responder -> requester  read data, valid at ack, held until next ack
//
// Modports:
//   master  requester side
//   slave   responder side
// -----------------------------------------------------------------------------
interface mem_resp_20b_if;
    logic        req;
    logic        we;
    logic        w;
    logic [19:0] addr;
    logic [15:0] wdata;
    logic        busy;
    logic        ack;
    logic        err;
    logic [15:0] rdata;

    modport master (
        output req,
        output we,
        output w,
        output addr,
        output wdata,
        input  busy,
        input  ack,
        input  err,
        input  rdata
    );

    modport slave (
        input  req,
        input  we,
        input  w,
        input  addr,
        input  wdata,
        output busy,
        output ack,
        output err,
        output rdata
    );
endinterface

// File: rtl/mem_resp_20b.sv
// -----------------------------------------------------------------------------
// mem_resp_20b
//
// Purpose:
//   Memory-side responder for 20-bit physical addresses. It accepts one byte
//   or word read/write at a time and models a byte-addressed, little-endian
//   memory with a configurable number of wait states. A word access at an odd
//   address is split into two byte bus cycles, the way an 8086 does it.
//
// Parameters:
//   MEM_BYTES    implemented memory size in bytes (valid addresses
//                0..MEM_BYTES-1, at most 2^20)
//   WAIT_STATES  idle cycles inserted before each byte-pair access (0..7)
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset (memory contents are not reset)
//   bus    mem_resp_20b_if.slave: req/we/w/addr/wdata in,
//          busy/ack/err/rdata out
//
// Optional build macro:
//   ALIGN_ERR_EN  when defined, an odd-address word access is rejected with
//                 err=1 instead of being split into two byte cycles.
// -----------------------------------------------------------------------------
module mem_resp_20b #(
    parameter int MEM_BYTES   = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_resp_20b_if.slave bus
);

    // Index width for the storage array; guard the degenerate 1-byte case.
    localparam int AW = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;

    // One extra bit so that MEM_BYTES = 2^20 is representable as a limit.
    localparam logic [20:0] MEM_LIMIT = 21'(MEM_BYTES);

    localparam bit         HAS_WAIT  = (WAIT_STATES > 0);
    localparam logic [2:0] WAIT_LAST = 3'(WAIT_STATES - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WAIT1 = 3'd1;
    localparam logic [2:0] ST_ACC1  = 3'd2;
    localparam logic [2:0] ST_WAIT2 = 3'd3;
    localparam logic [2:0] ST_ACC2  = 3'd4;
    localparam logic [2:0] ST_RESP  = 3'd5;

    logic [2:0]  state;
    logic [2:0]  state_next;

    // Request captured at the acceptance edge; the bus inputs are ignored
    // for the rest of the transaction.
    logic [19:0] addr_q;
    logic        we_q;
    logic        w_q;
    logic [15:0] wdata_q;

    logic [2:0]  wait_cnt;
    logic        err_q;
    logic [15:0] rdata_q;

    // Low byte of a split odd-word read, parked here so that rdata keeps
    // showing the previous result until this transaction's ack.
    logic [7:0]  rd_lo_q;

    logic [7:0]  mem [MEM_BYTES];

    logic [19:0]   addr_hi;
    logic [AW-1:0] lo_idx;
    logic [AW-1:0] hi_idx;
    logic          odd_word;
    logic          out_of_range;
    logic          align_fault;
    logic          acc_err;
    logic          wait_done;

    // The high byte address wraps from 20'hFFFFF to 20'h00000 naturally.
    assign addr_hi  = addr_q + 20'd1;
    assign lo_idx   = addr_q[AW-1:0];
    assign hi_idx   = addr_hi[AW-1:0];
    assign odd_word = w_q & addr_q[0];

    // Both bytes of a word must be in range before anything is touched, so
    // a rejected odd word never writes its low byte either.
    assign out_of_range = ({1'b0, addr_q} >= MEM_LIMIT) |
                          (w_q & ({1'b0, addr_hi} >= MEM_LIMIT));

`ifdef ALIGN_ERR_EN
    assign align_fault = odd_word;
`else
    assign align_fault = 1'b0;
`endif

    assign acc_err   = out_of_range | align_fault;
    assign wait_done = (wait_cnt == WAIT_LAST);

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (bus.req) begin
                    state_next = HAS_WAIT ? ST_WAIT1 : ST_ACC1;
                end
            end
            ST_WAIT1: begin
                if (wait_done) begin
                    state_next = ST_ACC1;
                end
            end
            ST_ACC1: begin
                // Only a legal odd word needs the second byte cycle.
                if (!acc_err && odd_word) begin
                    state_next = HAS_WAIT ? ST_WAIT2 : ST_ACC2;
                end else begin
                    state_next = ST_RESP;
                end
            end
            ST_WAIT2: begin
                if (wait_done) begin
                    state_next = ST_ACC2;
                end
            end
            ST_ACC2: begin
                state_next = ST_RESP;
            end
            ST_RESP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            addr_q   <= 20'h00000;
            we_q     <= 1'b0;
            w_q      <= 1'b0;
            wdata_q  <= 16'h0000;
            wait_cnt <= 3'd0;
            err_q    <= 1'b0;
            rdata_q  <= 16'h0000;
            rd_lo_q  <= 8'h00;
        end else begin
            state <= state_next;
            case (state)
                ST_IDLE: begin
                    if (bus.req) begin
                        addr_q   <= bus.addr;
                        we_q     <= bus.we;
                        w_q      <= bus.w;
                        wdata_q  <= bus.wdata;
                        err_q    <= 1'b0;
                        wait_cnt <= 3'd0;
                    end
                end
                ST_WAIT1, ST_WAIT2: begin
                    // Counter is left at zero on exit so WAIT2 starts clean.
                    wait_cnt <= wait_done ? 3'd0 : wait_cnt + 3'd1;
                end
                ST_ACC1: begin
                    if (acc_err) begin
                        err_q   <= 1'b1;
                        rdata_q <= 16'h0000;
                    end else if (!we_q) begin
                        if (!w_q) begin
                            rdata_q <= {8'h00, mem[lo_idx]};
                        end else if (!addr_q[0]) begin
                            rdata_q <= {mem[hi_idx], mem[lo_idx]};
                        end else begin
                            rd_lo_q <= mem[lo_idx];
                        end
                    end
                end
                ST_ACC2: begin
                    if (!we_q) begin
                        rdata_q <= {mem[hi_idx], rd_lo_q};
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Storage has no reset. Writes land at the edge that ends ACC1/ACC2; a
    // reset mid-transaction forces IDLE, so no later byte of it is written.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == ST_ACC1 && we_q && !acc_err) begin
                mem[lo_idx] <= wdata_q[7:0];
                if (w_q && !addr_q[0]) begin
                    mem[hi_idx] <= wdata_q[15:8];
                end
            end
            if (state == ST_ACC2 && we_q) begin
                mem[hi_idx] <= wdata_q[15:8];
            end
        end
    end

    assign bus.busy  = (state != ST_IDLE);
    assign bus.ack   = (state == ST_RESP);
    assign bus.err   = (state == ST_RESP) & err_q;
    assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_mem_resp_20b.sv
// -----------------------------------------------------------------------------
// tb_mem_resp_20b
//
// Purpose:
//   Self-checking directed testbench for mem_resp_20b with MEM_BYTES=1024 and
//   WAIT_STATES=1. Expected values are hand-computed constants. Latency is
//   counted as the index of the cycle after the acceptance edge in which ack
//   is high (cycle 1 is the one right after acceptance).
//
// Optional build macro:
//   ALIGN_ERR_EN  switches the odd-word expectations to the rejecting variant.
// -----------------------------------------------------------------------------
module tb_mem_resp_20b;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    mem_resp_20b_if bus ();

    mem_resp_20b #(
        .MEM_BYTES  (1024),
        .WAIT_STATES(1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Issue one request from idle and wait (bounded) for its ack.
    // lat = -1 means no ack arrived within the budget.
    task automatic apply_stimulus(input logic we_i, input logic w_i,
                                  input logic [19:0] a, input logic [15:0] d,
                                  output logic [15:0] rd, output logic er,
                                  output int lat);
        @(negedge clk);
        bus.req   = 1'b1;
        bus.we    = we_i;
        bus.w     = w_i;
        bus.addr  = a;
        bus.wdata = d;
        @(posedge clk);
        @(negedge clk);
        bus.req = 1'b0;
        lat = 1;
        while (bus.ack !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (bus.ack !== 1'b1) lat = -1;
        rd = bus.rdata;
        er = bus.err;
    endtask

    task automatic test_reset();
        bus.req   = 1'b0;
        bus.we    = 1'b0;
        bus.w     = 1'b0;
        bus.addr  = 20'h0;
        bus.wdata = 16'h0;
        rst_n     = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy);
        end
        checks++;
        if (bus.ack !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ack: got %b expected 0", bus.ack);
        end
        checks++;
        if (bus.err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_err: got %b expected 0", bus.err);
        end
        checks++;
        if (bus.rdata !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL reset_rdata: got %h expected 0000", bus.rdata);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_word_rw();
        logic [15:0] rd;
        logic        er;
        int          lat;
        apply_stimulus(1'b1, 1'b1, 20'h00010, 16'hBEEF, rd, er, lat);
        checks++;
        if (lat !== 3) begin
            errors++;
            $display("[TB] FAIL word_write_latency: got %0d expected 3", lat);
        end
        checks++;
        if (er !== 1'b0) begin
            errors++;
            $display("[TB] FAIL word_write_err: got %b expected 0", er);
        end
        apply_stimulus(1'b0, 1'b1, 20'h00010, 16'h0000, rd, er, lat);
        checks++;
        if (rd !== 16'hBEEF || lat !== 3) begin
            errors++;
            $display("[TB] FAIL word_read: got %h lat %0d expected beef lat 3", rd, lat);
        end
    endtask

    task automatic test_byte_access();
        logic [15:0] rd;
        logic        er;
        int          lat;
        apply_stimulus(1'b0, 1'b0, 20'h00011, 16'h0000, rd, er, lat);
        checks++;
        if (rd !== 16'h00BE || er !== 1'b0) begin
            errors++;
            $display("[TB] FAIL byte_read_hi: got %h err %b expected 00be err 0", rd, er);
        end
        apply_stimulus(1'b1, 1'b0, 20'h00010, 16'h0055, rd, er, lat);
        checks++;
        if (lat !== 3) begin
            errors++;
            $display("[TB] FAIL byte_write_latency: got %0d expected 3", lat);
        end
        apply_stimulus(1'b0, 1'b1, 20'h00010, 16'h0000, rd, er, lat);
        checks++;
        if (rd !== 16'hBE55) begin
            errors++;
            $display("[TB] FAIL merged_word_read: got %h expected be55", rd);
        end
    endtask

    task automatic test_odd_word();
        logic [15:0] rd;
        logic        er;
        int          lat;
        apply_stimulus(1'b1, 1'b0, 20'h00021, 16'h0011, rd, er, lat);
        apply_stimulus(1'b1, 1'b0, 20'h00022, 16'h0022, rd, er, lat);
        apply_stimulus(1'b1, 1'b1, 20'h00021, 16'h1234, rd, er, lat);
`ifdef ALIGN_ERR_EN
        checks++;
        if (lat !== 3 || er !== 1'b1) begin
            errors++;
            $display("[TB] FAIL odd_write_reject: got lat %0d err %b expected lat 3 err 1", lat, er);
        end
        apply_stimulus(1'b0, 1'b0, 20'h00021, 16'h0000, rd, er, lat);
        checks++;
        if (rd !== 16'h0011) begin
            errors++;
            $display("[TB] FAIL odd_low_unchanged: got %h expected 0011", rd);
        end
        apply_stimulus(1'b0, 1'b0, 20'h00022, 16'h0000, rd, er, lat);
        checks++;
        if (rd !== 16'h0022) begin
            errors++;
            $display("[TB] FAIL odd_high_unchanged: got %h expected 0022", rd);
        end
        apply_stimulus(1'b0, 1'b1, 20'h00021, 16'h0000, rd, er, lat);
        checks++;
        if (rd !== 16'h0000 || er !== 1'b1 || lat !== 3) begin
            errors++;
            $display("[TB] FAIL odd_read_reject: got %h err %b lat %0d expected 0000 err 1 lat 3", rd, er, lat);
        end
`else
        checks++;
        if (lat !== 5 || er !== 1'b0) begin
            errors++;
            $display("[TB] FAIL odd_write_latency: got lat %0d err %b expected lat 5 err 0", lat, er);
        end
        apply_stimulus(1'b0, 1'b0, 20'h00021, 16'h0000, rd, er, lat);
        checks++;
        if (rd !== 16'h0034) begin
            errors++;
            $display("[TB] FAIL odd_low_byte: got %h expected 0034", rd);
        end
        apply_stimulus(1'b0, 1'b0, 20'h00022, 16'h0000, rd, er, lat);
        checks++;
        if (rd !== 16'h0012) begin
            errors++;
            $display("[TB] FAIL odd_high_byte: got %h expected 0012", rd);
        end
        apply_stimulus(1'b0, 1'b1, 20'h00021, 16'h0000, rd, er, lat);
        checks++;
        if (rd !== 16'h1234 || er !== 1'b0 || lat !== 5) begin
            errors++;
            $display("[TB] FAIL odd_word_read: got %h err %b lat %0d expected 1234 err 0 lat 5", rd, er, lat);
        end
`endif
    endtask

    task automatic test_range();
        logic [15:0] rd;
        logic        er;
        int          lat;
        apply_stimulus(1'b1, 1'b0, 20'h003FF, 16'h005A, rd, er, lat);
        checks++;
        if (er !== 1'b0) begin
            errors++;
            $display("[TB] FAIL last_byte_write_err: got %b expected 0", er);
        end
        apply_stimulus(1'b0, 1'b0, 20'h00400, 16'h0000, rd, er, lat);
        checks++;
        if (er !== 1'b1 || rd !== 16'h0000 || lat !== 3) begin
            errors++;
            $display("[TB] FAIL range_byte_read: got err %b rdata %h lat %0d expected err 1 rdata 0000 lat 3", er, rd, lat);
        end
        apply_stimulus(1'b1, 1'b1, 20'h003FF, 16'hAAAA, rd, er, lat);
        checks++;
        if (er !== 1'b1 || lat !== 3) begin
            errors++;
            $display("[TB] FAIL range_word_write: got err %b lat %0d expected err 1 lat 3", er, lat);
        end
        apply_stimulus(1'b0, 1'b0, 20'h003FF, 16'h0000, rd, er, lat);
        checks++;
        if (rd !== 16'h005A || er !== 1'b0) begin
            errors++;
            $display("[TB] FAIL range_no_write: got %h err %b expected 005a err 0", rd, er);
        end
        apply_stimulus(1'b0, 1'b1, 20'hFFFFF, 16'h0000, rd, er, lat);
        checks++;
        if (er !== 1'b1 || rd !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL range_wrap_word: got err %b rdata %h expected err 1 rdata 0000", er, rd);
        end
    endtask

    task automatic test_back_to_back();
        int          lat;
        logic [15:0] expect_rd;
        // Even requests: word read 0x10 -> be55; odd: byte read 0x11 -> 00be.
        @(negedge clk);
        bus.req   = 1'b1;
        bus.we    = 1'b0;
        bus.w     = 1'b1;
        bus.addr  = 20'h00010;
        bus.wdata = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            expect_rd = (i % 2 == 0) ? 16'hBE55 : 16'h00BE;
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (bus.busy !== 1'b1) begin
                errors++;
                $display("[TB] FAIL b2b_accept_%0d: busy %b expected 1", i, bus.busy);
            end
            // Garbage write while busy; must be ignored.
            bus.we    = 1'b1;
            bus.w     = 1'b1;
            bus.addr  = 20'h00010;
            bus.wdata = 16'hDEAD;
            lat = 1;
            while (bus.ack !== 1'b1 && lat < 40) begin
                @(negedge clk);
                lat++;
            end
            if (bus.ack !== 1'b1) lat = -1;
            checks++;
            if (lat !== 3 || bus.rdata !== expect_rd) begin
                errors++;
                $display("[TB] FAIL b2b_resp_%0d: got lat %0d rdata %h expected lat 3 rdata %h", i, lat, bus.rdata, expect_rd);
            end
            if (i == 3) begin
                bus.req = 1'b0;
            end
            bus.we    = 1'b0;
            bus.w     = (i % 2 == 1);
            bus.addr  = (i % 2 == 1) ? 20'h00010 : 20'h00011;
            bus.wdata = 16'h0000;
            @(negedge clk);
            checks++;
            if (bus.busy !== 1'b0 || bus.ack !== 1'b0) begin
                errors++;
                $display("[TB] FAIL b2b_idle_gap_%0d: busy %b ack %b expected 0 0", i, bus.busy, bus.ack);
            end
        end
        bus.req = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [15:0] rd;
        logic        er;
        int          lat;
        int          ack_seen;
        apply_stimulus(1'b1, 1'b0, 20'h00031, 16'h0011, rd, er, lat);
        apply_stimulus(1'b1, 1'b0, 20'h00032, 16'h0077, rd, er, lat);
        @(negedge clk);
        bus.req   = 1'b1;
        bus.we    = 1'b1;
        bus.w     = 1'b1;
        bus.addr  = 20'h00031;
        bus.wdata = 16'hCAFE;
        @(posedge clk);
        @(negedge clk);
        bus.req = 1'b0;
        // Cycle 1 WAIT1, cycle 2 ACC1, cycle 3 WAIT2.
        @(negedge clk);
        @(negedge clk);
`ifndef ALIGN_ERR_EN
        checks++;
        if (bus.busy !== 1'b1 || bus.ack !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_in_wait2: busy %b ack %b expected 1 0", bus.busy, bus.ack);
        end
`endif
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.ack !== 1'b0 || bus.err !== 1'b0 || bus.rdata !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL mid_reset_outputs: busy %b ack %b err %b rdata %h expected all 0",
                     bus.busy, bus.ack, bus.err, bus.rdata);
        end
        ack_seen = 0;
        repeat (2) begin
            @(negedge clk);
            if (bus.ack === 1'b1) ack_seen++;
        end
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (bus.ack === 1'b1) ack_seen++;
        end
        checks++;
        if (ack_seen !== 0) begin
            errors++;
            $display("[TB] FAIL mid_no_ack: got %0d acks expected 0", ack_seen);
        end
        apply_stimulus(1'b0, 1'b0, 20'h00031, 16'h0000, rd, er, lat);
        checks++;
`ifdef ALIGN_ERR_EN
        if (rd !== 16'h0011) begin
            errors++;
            $display("[TB] FAIL mid_low_byte: got %h expected 0011", rd);
        end
`else
        if (rd !== 16'h00FE) begin
            errors++;
            $display("[TB] FAIL mid_low_byte: got %h expected 00fe", rd);
        end
`endif
        apply_stimulus(1'b0, 1'b0, 20'h00032, 16'h0000, rd, er, lat);
        checks++;
        if (rd !== 16'h0077) begin
            errors++;
            $display("[TB] FAIL mid_high_byte: got %h expected 0077", rd);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_word_rw();
        test_byte_access();
        test_odd_word();
        test_range();
        test_back_to_back();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
